// File: rtl/dot_clock_gen.sv
// Dot clock generator: phase-accumulator NCO producing a registered pixel
// clock, a one-cycle strobe on each of its rising edges, and a lock flag
// that rises after a fixed number of output periods.
//
// state    | meaning
// ---------+----------------------------------------------------------
// unlocked | lock_cnt < LOCK_CYCLES; counting dot_ce pulses
// locked   | lock_cnt == LOCK_CYCLES; counter saturated, locked held
module dot_clock_gen #(
    parameter int          ACC_WIDTH   = 32,
    parameter logic [63:0] PHASE_INC   = 64'd1 << (ACC_WIDTH - 1),
    parameter int          LOCK_CYCLES = 16
) (
    input  logic board,
    input  logic rst,
    output logic dotclock,
    output logic dot_ce,
    output logic locked
);

    localparam int              MSB    = ACC_WIDTH - 1;
    localparam logic [63:0]     INC_MAX = 64'd1 << (ACC_WIDTH - 1);
    localparam logic [MSB:0]    INC    = PHASE_INC[MSB:0];
    localparam logic [15:0]     LOCK_N = 16'(LOCK_CYCLES);

    if (ACC_WIDTH < 4 || ACC_WIDTH > 48) begin : g_bad_width
        $fatal(1, "dot_clock_gen: ACC_WIDTH must be 4..48");
    end
    if (PHASE_INC < 64'd1 || PHASE_INC > INC_MAX) begin : g_bad_inc
        $fatal(1, "dot_clock_gen: PHASE_INC must be 1..2**(ACC_WIDTH-1)");
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
        $fatal(1, "dot_clock_gen: LOCK_CYCLES must be 1..65535");
    end

    // Initial values equal reset values so an un-reset power-up looks
    // exactly like a freshly released reset.
    logic [MSB:0] acc      = '0;
    logic [MSB:0] acc_next;
    logic         dot_ce_q = 1'b0;
    logic         locked_q = 1'b0;
    logic [15:0]  lock_cnt = '0;

    // Next accumulator value; carry out of the top bit is discarded.
    always_comb begin
        acc_next = acc + INC;
    end

    // Accumulator, edge strobe and saturating lock counter.
    always_ff @(posedge board) begin
        if (rst) begin
            acc      <= '0;
            dot_ce_q <= 1'b0;
            locked_q <= 1'b0;
            lock_cnt <= '0;
        end else begin
            acc      <= acc_next;
            dot_ce_q <= ~acc[MSB] & acc_next[MSB];
            if (dot_ce_q && lock_cnt != LOCK_N) begin
                lock_cnt <= lock_cnt + 16'd1;
            end
            if (dot_ce_q && lock_cnt == LOCK_N - 16'd1) begin
                locked_q <= 1'b1;
            end
        end
    end

    // Outputs come straight off flops; dotclock is the accumulator MSB.
    assign dotclock = acc[MSB];
    assign dot_ce   = dot_ce_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_dot_clock_gen.sv
// Bench for dot_clock_gen: four instances with different accumulator
// settings share one clock and reset. A closed-form arithmetic model
// (edges since reset times increment) predicts every output each cycle.
module tb_dot_clock_gen;

    logic board = 1'b0;
    logic rst   = 1'b0;

    logic a_dclk, a_ce, a_lk;
    logic b_dclk, b_ce, b_lk;
    logic c_dclk, c_ce, c_lk;
    logic d_dclk, d_ce, d_lk;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] n  = 64'd0;   // board edges since reset release

    always #5 board = ~board;

    dot_clock_gen #(.ACC_WIDTH(32), .PHASE_INC(64'h8000_0000), .LOCK_CYCLES(16)) u_a (
        .board(board), .rst(rst), .dotclock(a_dclk), .dot_ce(a_ce), .locked(a_lk));
    dot_clock_gen #(.ACC_WIDTH(32), .PHASE_INC(64'h4000_0000), .LOCK_CYCLES(16)) u_b (
        .board(board), .rst(rst), .dotclock(b_dclk), .dot_ce(b_ce), .locked(b_lk));
    dot_clock_gen #(.ACC_WIDTH(8), .PHASE_INC(64'd3), .LOCK_CYCLES(16)) u_c (
        .board(board), .rst(rst), .dotclock(c_dclk), .dot_ce(c_ce), .locked(c_lk));
    dot_clock_gen #(.ACC_WIDTH(12), .PHASE_INC(64'd1000), .LOCK_CYCLES(5)) u_d (
        .board(board), .rst(rst), .dotclock(d_dclk), .dot_ce(d_ce), .locked(d_lk));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (n=%0d, t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    // Rising crossings of the MSB in the unwrapped sum k*inc, k = 1..m.
    function automatic logic [63:0] m_pulses(input logic [63:0] m, input int w, input logic [63:0] inc);
        return (m * inc + (64'd1 << (w - 1))) >> w;
    endfunction

    function automatic logic m_dclk(input logic [63:0] m, input int w, input logic [63:0] inc);
        logic [63:0] q;
        q = (m * inc) >> (w - 1);
        return q[0];
    endfunction

    task automatic check_one(input string nm, input int w, input logic [63:0] inc, input int l,
                             input logic dclk, input logic ce, input logic lk);
        logic e_ce, e_lk;
        e_ce = (n == 0) ? 1'b0 : (m_pulses(n, w, inc) != m_pulses(n - 64'd1, w, inc));
        e_lk = (n == 0) ? 1'b0 : (m_pulses(n - 64'd1, w, inc) >= 64'(l));
        chk({nm, ".dotclock"}, 64'(dclk), 64'(m_dclk(n, w, inc)));
        chk({nm, ".dot_ce"},   64'(ce),   64'(e_ce));
        chk({nm, ".locked"},   64'(lk),   64'(e_lk));
    endtask

    task automatic check_all();
        check_one("a", 32, 64'h8000_0000, 16, a_dclk, a_ce, a_lk);
        check_one("b", 32, 64'h4000_0000, 16, b_dclk, b_ce, b_lk);
        check_one("c", 8,  64'd3,         16, c_dclk, c_ce, c_lk);
        check_one("d", 12, 64'd1000,      5,  d_dclk, d_ce, d_lk);
    endtask

    // One board cycle: drive rst, advance the model at the edge, check on the falling edge.
    task automatic step(input logic r);
        rst = r;
        @(posedge board);
        n = r ? 64'd0 : n + 64'd1;
        @(negedge board);
        check_all();
    endtask

    initial begin
        logic exp_a [4];
        logic exp_b [4];
        int   pulses, run_len, runs_checked;
        logic prev_dclk, prev_ce, seen_edge;

        exp_a = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_b = '{1'b0, 1'b1, 1'b1, 1'b0};

        // Power-up without reset must look like a just-released reset.
        #1;
        check_all();

        // Reset, then the fixed early dotclock patterns of both fast instances.
        step(1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            chk("a.dclk_seq", 64'(a_dclk), 64'(exp_a[i]));
            chk("a.ce_seq",   64'(a_ce),   64'(exp_a[i]));
            chk("b.dclk_seq", 64'(b_dclk), 64'(exp_b[i]));
        end

        // Lock timing: low through edge 31, high from edge 32.
        while (n < 64'd31) step(1'b0);
        chk("a.locked_e31", 64'(a_lk), 64'd0);
        step(1'b0);
        chk("a.locked_e32", 64'(a_lk), 64'd1);
        step(1'b0);
        chk("a.dclk_hi_before_rst", 64'(a_dclk), 64'd1);

        // One-edge reset while locked with dotclock high, then a full relock.
        step(1'b1);
        chk("a.rst_dclk",   64'(a_dclk), 64'd0);
        chk("a.rst_ce",     64'(a_ce),   64'd0);
        chk("a.rst_locked", 64'(a_lk),   64'd0);
        while (n < 64'd31) step(1'b0);
        chk("a.relock_e31", 64'(a_lk), 64'd0);
        step(1'b0);
        chk("a.relock_e32", 64'(a_lk), 64'd1);

        // Non-power-of-two increment: pulse count over 256*8 cycles and phase lengths.
        step(1'b1);
        pulses = 0; run_len = 0; runs_checked = 0;
        prev_dclk = c_dclk; prev_ce = c_ce; seen_edge = 1'b0;
        for (int i = 0; i < 256 * 8; i++) begin
            step(1'b0);
            if (c_ce) pulses++;
            chk("c.ce_consec", 64'(c_ce & prev_ce), 64'd0);
            if (c_dclk != prev_dclk) begin
                if (seen_edge) begin
                    runs_checked++;
                    chk("c.phase_len", 64'((run_len == 42 || run_len == 43) ? 1 : 0), 64'd1);
                end
                seen_edge = 1'b1;
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_dclk = c_dclk;
            prev_ce   = c_ce;
        end
        chk("c.pulse_count", 64'(pulses), 64'd24);
        chk("c.runs_seen", 64'((runs_checked >= 40) ? 1 : 0), 64'd1);

        // Random reset pulses, every cycle checked against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dot_clock_gen.md
DOT_CLOCK_GEN -- requirements
Module: dot_clock_gen

Interface
REQ-001 Parameter ACC_WIDTH, default 32: phase accumulator width in bits; legal range 4..48.
REQ-002 Parameter PHASE_INC, default 2**(ACC_WIDTH-1): per-cycle accumulator increment; legal range 1..2**(ACC_WIDTH-1).
REQ-003 Parameter LOCK_CYCLES, default 16: number of dotclock rising edges before locked asserts; legal range 1..65535.
REQ-004 board  input  1  board clock; one clock; all logic on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 dotclock  output  1  generated pixel (dot) clock; registered, glitch-free.
REQ-007 dot_ce  output  1  one-board-cycle pulse marking each dotclock rising edge.
REQ-008 locked  output  1  high once the output has run LOCK_CYCLES dotclock periods since reset.

Function
REQ-009 The block SHALL hold an ACC_WIDTH-bit register acc; each non-reset board edge: acc <= (acc + PHASE_INC) mod 2**ACC_WIDTH (wrap-around, carry discarded).
REQ-010 dotclock SHALL equal acc[ACC_WIDTH-1] taken straight from the register, with no combinational logic after the flop.
REQ-011 Mean dotclock frequency SHALL be f_board * PHASE_INC / 2**ACC_WIDTH; max f_board/2 at PHASE_INC = 2**(ACC_WIDTH-1).
REQ-012 Power-of-two PHASE_INC SHALL give exact 50% duty and a fixed period; other values SHALL give ±1 board-cycle period jitter with exact long-term average.
REQ-013 dot_ce SHALL be registered: dot_ce <= ~acc[MSB] & acc_next[MSB], so it is high in exactly the board cycle in which dotclock first reads 1 after reading 0.
REQ-014 dot_ce SHALL never be high for two consecutive cycles.
REQ-015 A 16-bit saturating counter SHALL count board cycles with dot_ce high. It stops at LOCK_CYCLES.
REQ-016 locked SHALL rise on the board edge after the cycle carrying the LOCK_CYCLES-th dot_ce pulse, then stay high until reset.
REQ-017 PHASE_INC out of range SHALL be a fatal elaboration error.
REQ-018 Latency: reset release to first dotclock high SHALL be ceil(2**(ACC_WIDTH-1)/PHASE_INC) board edges.

Reset
REQ-019 While rst=1 at a board edge: acc, dotclock, dot_ce, locked and the lock counter SHALL all be 0 after that edge.
REQ-020 Reset asserted mid-operation SHALL override all other updates on that edge; dotclock low, locked low, lock count restarts from 0.
REQ-021 Initial register values SHALL match reset values, so power-up without reset behaves as a just-released reset.

Verification
REQ-022 ACC_WIDTH=32, PHASE_INC=2**31, rst released at edge 0 -> dotclock after edges 1,2,3,4 = 1,0,1,0; dot_ce = 1,0,1,0.
REQ-023 PHASE_INC=2**30 -> dotclock pattern 0,1,1,0 repeating from reset release (period 4, duty 50%); dot_ce high one cycle per period.
REQ-024 ACC_WIDTH=8, PHASE_INC=3, run 256*N board cycles -> exactly 3*N dot_ce pulses; every high and low phase 42 or 43 cycles.
REQ-025 LOCK_CYCLES=16, PHASE_INC=2**31 -> locked low through the 16th dot_ce pulse (edge 31); high from edge 32 on.
REQ-026 Assert rst for one edge after locked=1 with dotclock high -> next cycle dotclock=0, dot_ce=0, locked=0; relock takes a full 16 pulses again.
